ccc_reconfig_sequencer: RTL and testbench

- APB master and sequencer that dynamically reconfigures the fabric CCC/PLL feeding the FSM global clock (GL0).
- On request, holds the PLL in reset, writes a caller-supplied register image over the CCC configuration APB port, reads back and verifies each byte, releases reset, and qualifies LOCK.
- Monitors lock after completion; reports status to the FSM control registers.
- Runs in the always-on configuration clock domain, never in the domain of GL0.

---
 rtl/ccc_reconfig_sequencer_pkg.sv | 27 ++
 rtl/ccc_reconfig_sequencer_if.sv | 18 +
 rtl/ccc_reconfig_sequencer_lock_qualifier.sv | 71 +++++++
 rtl/ccc_reconfig_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_ccc_reconfig_sequencer.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ccc_reconfig_sequencer_pkg.sv
// Shared types and constants for the CCC/PLL reconfiguration sequencer.
//   state_e      : sequencer FSM states
//   ERR_*        : err_code encodings reported to the FSM control registers
//   APB_*_W      : CCC configuration APB address/data widths
package ccc_reconfig_pkg;

    localparam int APB_ADDR_W = 6;
    localparam int APB_DATA_W = 8;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISMATCH = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HOLD_RST,
        ST_WR_SETUP,
        ST_WR_ACCESS,
        ST_RD_SETUP,
        ST_RD_ACCESS,
        ST_RELEASE,
        ST_WAIT_LOCK,
        ST_LOCKED,
        ST_ERROR
    } state_e;

endpackage

// File: rtl/ccc_reconfig_sequencer_if.sv
// APB port between the reconfiguration sequencer (master) and the CCC
// configuration interface (slave). The CCC has no PREADY/PSLVERR.
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA : master -> CCC
//   PRDATA                           : CCC -> master
interface ccc_reconfig_sequencer_if;
    import ccc_reconfig_pkg::*;

    logic [APB_ADDR_W-1:0] PADDR;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [APB_DATA_W-1:0] PWDATA;
    logic [APB_DATA_W-1:0] PRDATA;

    modport master (output PADDR, PSEL, PENABLE, PWRITE, PWDATA, input PRDATA);
    modport slave  (input PADDR, PSEL, PENABLE, PWRITE, PWDATA, output PRDATA);

endinterface

// File: rtl/ccc_reconfig_sequencer_lock_qualifier.sv
// Lock qualification for the reconfigured PLL.
//   PCLK, PRESET_N : configuration clock, async active-low reset
//   LOCK           : raw CCC lock (asynchronous), synchronized here
//   clear_i        : reload both timers (sequencer in RELEASE)
//   run_i          : timers active (sequencer in WAIT_LOCK)
//   qualified_o    : synchronized lock stayed high LOCK_STABLE cycles
//   timeout_o      : LOCK_TIMEOUT cycles elapsed since clear
//   fell_o         : synchronized lock is currently low
module ccc_lock_qualifier #(
    parameter int LOCK_TIMEOUT = 65535,
    parameter int LOCK_STABLE  = 256
) (
    input  logic PCLK,
    input  logic PRESET_N,
    input  logic LOCK,
    input  logic clear_i,
    input  logic run_i,
    output logic qualified_o,
    output logic timeout_o,
    output logic fell_o
);

    // Widths hold the load value itself; timers stop at zero, so no wrap.
    localparam int STB_W = $clog2(LOCK_STABLE + 1);
    localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [STB_W-1:0] STB_LOAD = STB_W'(LOCK_STABLE);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(LOCK_TIMEOUT);

    logic [1:0]       sync_q;
    logic [STB_W-1:0] stable_q, stable_d;
    logic [TMO_W-1:0] timeout_q, timeout_d;
    logic             lock_s;

    assign lock_s = sync_q[1];

    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
            sync_q    <= 2'b00;
            stable_q  <= STB_LOAD;
            timeout_q <= TMO_LOAD;
        end else begin
            sync_q    <= {sync_q[0], LOCK};
            stable_q  <= stable_d;
            timeout_q <= timeout_d;
        end
    end

    // Down-counters: a dropout of lock_s reloads the stable timer.
    always_comb begin
        stable_d  = stable_q;
        timeout_d = timeout_q;
        if (clear_i) begin
            stable_d  = STB_LOAD;
            timeout_d = TMO_LOAD;
        end else if (run_i) begin
            if (!lock_s) begin
                stable_d = STB_LOAD;
            end else if (stable_q != '0) begin
                stable_d = stable_q - STB_W'(1);
            end
            if (timeout_q != '0) begin
                timeout_d = timeout_q - TMO_W'(1);
            end
        end
    end

    assign qualified_o = (stable_q == '0);
    assign timeout_o   = (timeout_q == '0);
    assign fell_o      = !lock_s;

endmodule

// File: rtl/ccc_reconfig_sequencer.sv
// Reconfigures the fabric CCC/PLL feeding GL0: holds the PLL in reset, writes
// and read-verifies a register image over APB, releases reset and qualifies
// LOCK. Clocked by the always-on configuration clock, never by GL0.
//   PCLK, PRESET_N   : configuration clock, async active-low reset
//   start, cfg_image : request and register image (byte i = cfg_image[8i+7:8i])
//   LOCK             : raw CCC lock
//   apb              : APB master to the CCC configuration port
//   PLL_ARST_N       : PLL reset, active-low
//   busy, done, error, err_code, err_index, locked, lock_lost : status
//
// state        | meaning
// -------------+--------------------------------------------------
// ST_IDLE      | waiting for start, PLL running on current config
// ST_HOLD_RST  | PLL held in reset before the first write
// ST_WR_SETUP  | APB write setup phase for byte idx
// ST_WR_ACCESS | APB write access phase for byte idx
// ST_RD_SETUP  | APB read setup phase for byte idx
// ST_RD_ACCESS | APB read access phase, compare readback
// ST_RELEASE   | PLL reset released, lock timers reloaded
// ST_WAIT_LOCK | waiting for stable lock or timeout
// ST_LOCKED    | lock qualified, watching for loss of lock
// ST_ERROR     | readback mismatch or lock timeout
module ccc_reconfig_sequencer
    import ccc_reconfig_pkg::*;
#(
    parameter int                    NUM_REGS        = 27,
    parameter logic [APB_ADDR_W-1:0] BASE_ADDR       = 6'h00,
    parameter int                    RST_HOLD_CYCLES = 16,
    parameter int                    LOCK_TIMEOUT    = 65535,
    parameter int                    LOCK_STABLE     = 256
) (
    input  logic                  PCLK,
    input  logic                  PRESET_N,
    input  logic                  start,
    input  logic [NUM_REGS*8-1:0] cfg_image,
    input  logic                  LOCK,
    ccc_reconfig_sequencer_if.master apb,
    output logic                  PLL_ARST_N,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [4:0]            err_index,
    output logic                  locked,
    output logic                  lock_lost
);

    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam int SEL_W  = $clog2(NUM_REGS * 8);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REGS - 1);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [1:0]            err_code_q, err_code_d;
    logic [IDX_W-1:0]      err_index_q, err_index_d;
    logic                  lock_lost_q, lock_lost_d;
    logic                  lk_qualified, lk_timeout, lk_fell;
    logic [SEL_W-1:0]      bit_base;
    logic [7:0]            cfg_byte;
    logic [APB_ADDR_W-1:0] paddr;
    logic                  psel, penable, pwrite;
    logic [APB_DATA_W-1:0] pwdata;

    assign bit_base = SEL_W'(idx_q) << 3;
    assign cfg_byte = cfg_image[bit_base +: 8];

    ccc_lock_qualifier #(
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .LOCK_STABLE  (LOCK_STABLE)
    ) u_lock_qual (
        .PCLK        (PCLK),
        .PRESET_N    (PRESET_N),
        .LOCK        (LOCK),
        .clear_i     (state_q == ST_RELEASE),
        .run_i       (state_q == ST_WAIT_LOCK),
        .qualified_o (lk_qualified),
        .timeout_o   (lk_timeout),
        .fell_o      (lk_fell)
    );

    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            hold_q      <= '0;
            err_code_q  <= ERR_NONE;
            err_index_q <= '0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            err_code_q  <= err_code_d;
            err_index_q <= err_index_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        err_code_d  = err_code_q;
        err_index_d = err_index_q;
        lock_lost_d = lock_lost_q;
        psel        = 1'b0;
        penable     = 1'b0;
        pwrite      = 1'b0;
        paddr       = '0;
        pwdata      = '0;
        PLL_ARST_N  = 1'b1;
        done        = 1'b0;

        case (state_q)
            ST_IDLE: ;
            ST_HOLD_RST: begin
                PLL_ARST_N = 1'b0;
                if (hold_q == '0) begin
                    state_d = ST_WR_SETUP;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            ST_WR_SETUP, ST_WR_ACCESS: begin
                PLL_ARST_N = 1'b0;
                psel       = 1'b1;
                penable    = (state_q == ST_WR_ACCESS);
                pwrite     = 1'b1;
                paddr      = BASE_ADDR + APB_ADDR_W'(idx_q);
                pwdata     = cfg_byte;
                state_d    = (state_q == ST_WR_SETUP) ? ST_WR_ACCESS : ST_RD_SETUP;
            end
            ST_RD_SETUP: begin
                PLL_ARST_N = 1'b0;
                psel       = 1'b1;
                paddr      = BASE_ADDR + APB_ADDR_W'(idx_q);
                state_d    = ST_RD_ACCESS;
            end
            ST_RD_ACCESS: begin
                PLL_ARST_N = 1'b0;
                psel       = 1'b1;
                penable    = 1'b1;
                paddr      = BASE_ADDR + APB_ADDR_W'(idx_q);
                if (apb.PRDATA != cfg_byte) begin
                    err_index_d = idx_q;
                    err_code_d  = ERR_MISMATCH;
                    state_d     = ST_ERROR;
                end else if (idx_q == LAST_IDX) begin
                    state_d = ST_RELEASE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_WR_SETUP;
                end
            end
            ST_RELEASE: state_d = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                // Lock has priority when both timers expire together.
                if (lk_qualified) begin
                    done    = 1'b1;
                    state_d = ST_LOCKED;
                end else if (lk_timeout) begin
                    err_code_d = ERR_TIMEOUT;
                    state_d    = ST_ERROR;
                end
            end
            ST_LOCKED: begin
                if (lk_fell) begin
                    lock_lost_d = 1'b1;
                end
            end
            ST_ERROR: ;
            default: state_d = ST_IDLE;
        endcase

        // Restart from any resting state; takes precedence over lock_lost.
        if (start && (state_q == ST_IDLE || state_q == ST_LOCKED || state_q == ST_ERROR)) begin
            err_code_d  = ERR_NONE;
            lock_lost_d = 1'b0;
            idx_d       = '0;
            hold_d      = HOLD_LOAD;
            state_d     = ST_HOLD_RST;
        end
    end

    assign apb.PSEL    = psel;
    assign apb.PENABLE = penable;
    assign apb.PWRITE  = pwrite;
    assign apb.PADDR   = paddr;
    assign apb.PWDATA  = pwdata;

    assign busy      = !(state_q == ST_IDLE || state_q == ST_LOCKED || state_q == ST_ERROR);
    assign error     = (state_q == ST_ERROR);
    assign locked    = (state_q == ST_LOCKED);
    assign err_code  = err_code_q;
    assign err_index = 5'(err_index_q);
    assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_ccc_reconfig_sequencer.sv
module tb_ccc_reconfig_sequencer;
    import ccc_reconfig_pkg::*;

    localparam int NUM_REGS     = 27;
    localparam int RST_HOLD     = 16;
    localparam int LOCK_TIMEOUT = 1000;
    localparam int LOCK_STABLE  = 256;
    // Cycles from the cycle after the start edge to the RELEASE cycle.
    localparam int XFER_CYCLES  = RST_HOLD + 4 * NUM_REGS;

    logic                  PCLK = 1'b0;
    logic                  PRESET_N = 1'b0;
    logic                  start = 1'b0;
    logic                  LOCK = 1'b0;
    logic [NUM_REGS*8-1:0] cfg_image;
    logic                  PLL_ARST_N, busy, done, error, locked, lock_lost;
    logic [1:0]            err_code;
    logic [4:0]            err_index;
    logic                  corrupt_en = 1'b0;

    logic [7:0] mem    [0:63];
    logic [5:0] wr_log [0:2047];
    logic [5:0] rd_log [0:2047];
    int wr_cnt = 0;
    int rd_cnt = 0;
    int checks = 0;
    int errors = 0;

    ccc_reconfig_sequencer_if apb();

    ccc_reconfig_sequencer #(
        .NUM_REGS        (NUM_REGS),
        .BASE_ADDR       (6'h00),
        .RST_HOLD_CYCLES (RST_HOLD),
        .LOCK_TIMEOUT    (LOCK_TIMEOUT),
        .LOCK_STABLE     (LOCK_STABLE)
    ) dut (
        .PCLK       (PCLK),
        .PRESET_N   (PRESET_N),
        .start      (start),
        .cfg_image  (cfg_image),
        .LOCK       (LOCK),
        .apb        (apb),
        .PLL_ARST_N (PLL_ARST_N),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .err_index  (err_index),
        .locked     (locked),
        .lock_lost  (lock_lost)
    );

    always #5 PCLK = ~PCLK;

    // CCC model: echoes written bytes, optionally corrupting address 5.
    assign apb.PRDATA = (corrupt_en && apb.PADDR == 6'd5) ? (mem[apb.PADDR] ^ 8'h5A) : mem[apb.PADDR];

    always @(posedge PCLK) begin
        if (apb.PSEL && apb.PENABLE) begin
            if (apb.PWRITE) begin
                mem[apb.PADDR]     <= apb.PWDATA;
                wr_log[wr_cnt[10:0]] <= apb.PADDR;
                wr_cnt             <= wr_cnt + 1;
            end else begin
                rd_log[rd_cnt[10:0]] <= apb.PADDR;
                rd_cnt             <= rd_cnt + 1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_release(output int n);
        n = 0;
        while (!PLL_ARST_N && n < 2000) begin
            step(1);
            n++;
        end
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (n < limit) begin
            step(1);
            n++;
            if (done) break;
        end
    endtask

    task automatic test_reset();
        logic [29:0] got;
        #2;
        got = {apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA, PLL_ARST_N,
               busy, done, error, locked, lock_lost, err_code, err_index};
        checks++; if (got !== {3'b000, 6'd0, 8'd0, 1'b1, 5'b00000, 2'b00, 5'd0}) begin errors++; $display("FAIL reset_values: got %0h expected %0h", got, {3'b000, 6'd0, 8'd0, 1'b1, 5'b00000, 2'b00, 5'd0}); end
        @(posedge PCLK); #1;
        step(1);
        PRESET_N = 1'b1;
        step(3);
        checks++; if ({busy, PLL_ARST_N, apb.PSEL} !== 3'b010) begin errors++; $display("FAIL idle_no_start: got %b expected 010", {busy, PLL_ARST_N, apb.PSEL}); end
    endtask

    task automatic test_nominal();
        int n, wb, rb, bad;
        LOCK = 1'b0;
        wb = wr_cnt; rb = rd_cnt;
        pulse_start();
        checks++; if ({busy, PLL_ARST_N} !== 2'b10) begin errors++; $display("FAIL nom_busy_arst: got %b expected 10", {busy, PLL_ARST_N}); end
        wait_release(n);
        checks++; if (n !== XFER_CYCLES) begin errors++; $display("FAIL nom_release_latency: got %0d expected %0d", n, XFER_CYCLES); end
        checks++; if (wr_cnt - wb !== NUM_REGS || rd_cnt - rb !== NUM_REGS) begin errors++; $display("FAIL nom_xfer_count: got wr %0d rd %0d expected %0d", wr_cnt - wb, rd_cnt - rb, NUM_REGS); end
        bad = 0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_log[11'(wb + i)] != 6'(i) || rd_log[11'(rb + i)] != 6'(i) || mem[i] != cfg_image[8*i +: 8]) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL nom_addr_data: got %0d bad bytes expected 0", bad); end
        step(100);
        LOCK = 1'b1;
        wait_done(400, n);
        checks++; if (n !== LOCK_STABLE + 2) begin errors++; $display("FAIL nom_done_latency: got %0d expected %0d", n, LOCK_STABLE + 2); end
        step(1);
        checks++; if ({done, locked, busy, error} !== 4'b0100) begin errors++; $display("FAIL nom_after_done: got %b expected 0100", {done, locked, busy, error}); end
    endtask

    task automatic test_start_while_busy();
        int n, wb, dc;
        LOCK = 1'b0;
        wb = wr_cnt;
        pulse_start();
        wait_release(n);
        step(5);
        pulse_start();
        checks++; if ({busy, PLL_ARST_N} !== 2'b11) begin errors++; $display("FAIL swb_ignored: got %b expected 11", {busy, PLL_ARST_N}); end
        LOCK = 1'b1;
        dc = 0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (done) dc++;
        end
        checks++; if (dc !== 1) begin errors++; $display("FAIL swb_done_count: got %0d expected 1", dc); end
        checks++; if ({locked, error, 32'(wr_cnt - wb)} !== {2'b10, 32'(NUM_REGS)}) begin errors++; $display("FAIL swb_final: got locked %b error %b writes %0d expected 1 0 %0d", locked, error, wr_cnt - wb, NUM_REGS); end
    endtask

    task automatic test_lock_glitch();
        int n, dc;
        LOCK = 1'b0;
        pulse_start();
        wait_release(n);
        step(10);
        LOCK = 1'b1;
        dc = 0;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (done) dc++;
        end
        LOCK = 1'b0;
        step(1);
        LOCK = 1'b1;
        checks++; if (dc !== 0) begin errors++; $display("FAIL glitch_early_done: got %0d expected 0", dc); end
        wait_done(400, n);
        checks++; if (n !== LOCK_STABLE + 2) begin errors++; $display("FAIL glitch_done_latency: got %0d expected %0d", n, LOCK_STABLE + 2); end
        step(1);
        checks++; if ({locked, lock_lost} !== 2'b10) begin errors++; $display("FAIL glitch_locked: got %b expected 10", {locked, lock_lost}); end
        LOCK = 1'b0;
        step(4);
        checks++; if ({locked, lock_lost} !== 2'b11) begin errors++; $display("FAIL glitch_lock_lost: got %b expected 11", {locked, lock_lost}); end
        LOCK = 1'b1;
        step(5);
        checks++; if ({locked, lock_lost, done} !== 3'b110) begin errors++; $display("FAIL glitch_lost_sticky: got %b expected 110", {locked, lock_lost, done}); end
    endtask

    task automatic test_readback_fault();
        int n, wb;
        LOCK = 1'b0;
        corrupt_en = 1'b1;
        wb = wr_cnt;
        pulse_start();
        checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL fault_lost_cleared: got %b expected 0", lock_lost); end
        n = 0;
        while (!error && n < 500) begin
            step(1);
            n++;
        end
        checks++; if (n !== RST_HOLD + 4 * 6) begin errors++; $display("FAIL fault_latency: got %0d expected %0d", n, RST_HOLD + 4 * 6); end
        checks++; if ({error, err_code, err_index} !== {1'b1, ERR_MISMATCH, 5'd5}) begin errors++; $display("FAIL fault_status: got %b expected %b", {error, err_code, err_index}, {1'b1, ERR_MISMATCH, 5'd5}); end
        checks++; if ({busy, PLL_ARST_N} !== 2'b01) begin errors++; $display("FAIL fault_arst: got %b expected 01", {busy, PLL_ARST_N}); end
        step(5);
        checks++; if (wr_cnt - wb !== 6 || wr_log[11'(wb + 5)] !== 6'd5) begin errors++; $display("FAIL fault_writes: got %0d writes last addr %0d expected 6 writes last 5", wr_cnt - wb, wr_log[11'(wb + 5)]); end
        corrupt_en = 1'b0;
    endtask

    task automatic test_lock_timeout();
        int n, dc;
        LOCK = 1'b0;
        pulse_start();
        checks++; if ({error, err_code} !== 3'b000) begin errors++; $display("FAIL tmo_err_cleared: got %b expected 000", {error, err_code}); end
        wait_release(n);
        n = 0; dc = 0;
        while (!error && n < 1100) begin
            step(1);
            n++;
            if (done) dc++;
        end
        checks++; if (n !== LOCK_TIMEOUT + 2) begin errors++; $display("FAIL tmo_latency: got %0d expected %0d", n, LOCK_TIMEOUT + 2); end
        checks++; if ({err_code, busy, PLL_ARST_N, 32'(dc)} !== {ERR_TIMEOUT, 2'b01, 32'd0}) begin errors++; $display("FAIL tmo_status: got code %b busy %b arst %b dones %0d expected 10 0 1 0", err_code, busy, PLL_ARST_N, dc); end
    endtask

    task automatic test_mid_reset();
        int n, wb, wb2;
        logic [29:0] got;
        wb = wr_cnt;
        pulse_start();
        step(RST_HOLD + 4 * 10 + 1);
        checks++; if ({apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR} !== {3'b111, 6'd10}) begin errors++; $display("FAIL mid_wr_access10: got %b expected %b", {apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR}, {3'b111, 6'd10}); end
        #2;
        PRESET_N = 1'b0;
        #1;
        got = {apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA, PLL_ARST_N,
               busy, done, error, locked, lock_lost, err_code, err_index};
        checks++; if (got !== {3'b000, 6'd0, 8'd0, 1'b1, 5'b00000, 2'b00, 5'd0}) begin errors++; $display("FAIL mid_reset_values: got %0h expected %0h", got, {3'b000, 6'd0, 8'd0, 1'b1, 5'b00000, 2'b00, 5'd0}); end
        @(posedge PCLK); #1;
        step(1);
        PRESET_N = 1'b1;
        step(2);
        checks++; if (wr_cnt - wb !== 10) begin errors++; $display("FAIL mid_partial_writes: got %0d expected 10", wr_cnt - wb); end
        wb2 = wr_cnt;
        pulse_start();
        wait_release(n);
        checks++; if (n !== XFER_CYCLES || wr_cnt - wb2 !== NUM_REGS || wr_log[11'(wb2)] !== 6'd0) begin errors++; $display("FAIL mid_restart: got latency %0d writes %0d first addr %0d expected %0d %0d 0", n, wr_cnt - wb2, wr_log[11'(wb2)], XFER_CYCLES, NUM_REGS); end
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) begin
            cfg_image[8*i +: 8] = 8'((i * 37 + 27) & 8'hFF);
        end
        test_reset();
        test_nominal();
        test_start_while_busy();
        test_lock_glitch();
        test_readback_fault();
        test_lock_timeout();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
